// File: rtl/std_mult_seq.sv
// std_mult_seq
// -----------------------------------------------------------------------------
// Sequential unsigned shift-and-add multiplier with a go/done handshake.
// One adder is shared across all steps, so latency depends on the data: the
// loop ends as soon as either the shifted multiplicand or the shifted
// multiplier reaches zero. The result is the low `width` bits of left*right.
//
// Parameters:
//   width  - operand and result width in bits (default 32)
//
// Ports:
//   clk    in   1      rising-edge clock
//   reset  in   1      asynchronous active-high reset
//   go     in   1      request, held high by the controller until done is seen
//   left   in   width  multiplicand, sampled only at the start edge
//   right  in   width  multiplier, sampled only at the start edge
//   out    out  width  product (low width bits), held until next start/abort
//   done   out  1      one-cycle completion pulse
//
// Optional build macro:
//   STD_MULT_SEQ_CHECK_EN - adds a simulation-only shadow product that is
//   compared against out whenever done is high. Has no effect on out, done
//   or latency. Leave undefined for synthesis.
// -----------------------------------------------------------------------------
module std_mult_seq #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [width-1:0] left,
  input  logic [width-1:0] right,
  output logic [width-1:0] out,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [width-1:0] mcand, mcand_next;
  logic [width-1:0] mplier, mplier_next;
  logic [width-1:0] acc, acc_next;
  logic [width-1:0] out_next;
  logic             done_next;

  // All architectural state, including the registered outputs, lives here so
  // that out and done never have a combinational path from any input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      out    <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      mcand  <= mcand_next;
      mplier <= mplier_next;
      acc    <= acc_next;
      out    <= out_next;
      done   <= done_next;
    end
  end

  // Next-state and datapath control. Registers hold by default and done is a
  // pulse, so it defaults low. In RUN an abort outranks completion, and
  // completion is detected before stepping: once either shifted operand is
  // zero no further partial products can contribute, which is what makes the
  // latency data dependent.
  always_comb begin
    state_next  = state;
    mcand_next  = mcand;
    mplier_next = mplier;
    acc_next    = acc;
    out_next    = out;
    done_next   = 1'b0;

    case (state)
      IDLE: begin
        if (go) begin
          mcand_next  = left;
          mplier_next = right;
          acc_next    = '0;
          state_next  = RUN;
        end
      end

      RUN: begin
        if (!go) begin
          out_next   = '0;
          state_next = IDLE;
        end else if (mplier == '0 || mcand == '0) begin
          out_next   = acc;
          done_next  = 1'b1;
          state_next = DONE;
        end else begin
          if (mplier[0]) begin
            acc_next = acc + mcand;
          end
          mcand_next  = mcand << 1;
          mplier_next = mplier >> 1;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef STD_MULT_SEQ_CHECK_EN
  logic [width-1:0] shadow;
  logic [width-1:0] shadow_left;
  logic [width-1:0] shadow_right;

  // Reference product captured alongside the operands at the start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow       <= '0;
      shadow_left  <= '0;
      shadow_right <= '0;
    end else if (state == IDLE && go) begin
      shadow       <= left * right;
      shadow_left  <= left;
      shadow_right <= right;
    end
  end

  // Compare the delivered product against the reference while done is high.
  always @(posedge clk) begin
    if (!reset && done && (out !== shadow)) begin
      $error("std_mult_seq: %0d * %0d expected %0d computed %0d",
             shadow_left, shadow_right, shadow, out);
    end
  end
`endif

endmodule

// File: tb/tb_std_mult_seq.sv
// tb_std_mult_seq
// -----------------------------------------------------------------------------
// Scoreboard bench for std_mult_seq (width = 32). The stimulus side pushes the
// expected product and the expected edge number of the done pulse for each
// operation; an independent monitor pops an entry every time done is seen and
// compares both. Any done pulse with nothing expected is a miscompare, which
// also covers aborts and the single-cycle width of done.
// -----------------------------------------------------------------------------
module tb_std_mult_seq;

  typedef struct {
    logic [31:0] prod;
    int          done_edge;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        go;
  logic [31:0] left;
  logic [31:0] right;
  logic [31:0] out;
  logic        done;

  exp_t sb[$];
  int   cyc;
  int   vectors;
  int   miscompares;

  std_mult_seq #(.width(32)) dut (
    .clk   (clk),
    .reset (reset),
    .go    (go),
    .left  (left),
    .right (right),
    .out   (out),
    .done  (done)
  );

  // 100 MHz-style free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after posedge n, cyc == n.
  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_done: done=1 out=%h at edge %0d, nothing expected", out, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        vectors++;
        if (out !== e.prod) begin
          miscompares++;
          $display("[TB] FAIL product: out=%h expected=%h", out, e.prod);
        end
        vectors++;
        if (cyc != e.done_edge) begin
          miscompares++;
          $display("[TB] FAIL done_edge: done at edge %0d expected edge %0d", cyc, e.done_edge);
        end
      end
    end
  end

  // Generic compare used by the stimulus side.
  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drive one operation at a falling edge. start_ofs is how many edges away
  // the start edge is (1 from idle, 2 when go is held through a DONE cycle).
  // lat is the hand-computed 1 + min(L, R). Nothing is pushed when the
  // operation is going to be aborted or reset.
  task automatic apply_stimulus(input logic [31:0] l, input logic [31:0] r,
                                input logic [31:0] prod, input int lat,
                                input int start_ofs, input bit expect_done);
    exp_t e;
    left  = l;
    right = r;
    go    = 1'b1;
    if (expect_done) begin
      e.prod      = prod;
      e.done_edge = cyc + start_ofs + lat;
      sb.push_back(e);
    end
  endtask

  // Bounded wait for done; optionally keep go high for a back-to-back start.
  task automatic wait_done(input bit keep_go);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL timeout: done not seen within 64 cycles at edge %0d", cyc);
    end
    if (!keep_go) go = 1'b0;
  endtask

  initial begin
    cyc         = 0;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    go          = 1'b0;
    left        = '0;
    right       = '0;

    repeat (2) @(negedge clk);
    check_output("reset_out", out, 32'd0);
    check_output("reset_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Zero operands, go held high across both operations.
    apply_stimulus(32'd0, 32'd12345, 32'd0, 1, 1, 1'b1);
    wait_done(1'b1);
    apply_stimulus(32'd7, 32'd0, 32'd0, 1, 2, 1'b1);
    wait_done(1'b0);
    @(negedge clk);

    // Basic product: R = 3, L = 31 -> latency 4.
    apply_stimulus(32'd6, 32'd7, 32'd42, 4, 1, 1'b1);
    wait_done(1'b0);
    @(negedge clk);
    check_output("hold_after_go_drop", out, 32'd42);
    @(negedge clk);

    // Wrap and worst case: 33 edges.
    apply_stimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 1, 1'b1);
    wait_done(1'b0);
    @(negedge clk);

    // Operands change after the start edge: R = 2, L = 30 -> latency 3.
    apply_stimulus(32'd100, 32'd3, 32'd300, 3, 1, 1'b1);
    @(negedge clk);
    left  = '0;
    right = '0;
    wait_done(1'b0);
    @(negedge clk);

    // Abort: drop go three cycles after driving the request.
    apply_stimulus(32'd5, 32'd255, 32'd0, 9, 1, 1'b0);
    repeat (3) @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    check_output("abort_out", out, 32'd0);
    @(negedge clk);
    apply_stimulus(32'd2, 32'd3, 32'd6, 3, 1, 1'b1);
    wait_done(1'b0);
    @(negedge clk);

    // Reset mid-operation, asserted between edges.
    apply_stimulus(32'd1, 32'hFFFF_FFFF, 32'd0, 33, 1, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    go    = 1'b0;
    #1;
    check_output("midrun_reset_out", out, 32'd0);
    check_output("midrun_reset_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    // 9 x 9: R = 4, L = 32 -> latency 5; a start on the next edge shows IDLE.
    apply_stimulus(32'd9, 32'd9, 32'd81, 5, 1, 1'b1);
    wait_done(1'b0);
    @(negedge clk);

    // Back-to-back with go held high throughout.
    apply_stimulus(32'd3, 32'd5, 32'd15, 4, 1, 1'b1);
    wait_done(1'b1);
    apply_stimulus(32'd10, 32'd10, 32'd100, 5, 2, 1'b1);
    wait_done(1'b1);
    apply_stimulus(32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 18, 2, 1'b1);
    wait_done(1'b0);

    repeat (4) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/std_mult_seq.md
# std_mult_seq

Sequential unsigned shift-and-add multiplier, the multiplicative counterpart of the shift-subtract divider in the bitnum primitive library. It uses the standard `go`/`done` latency-insensitive handshake, so the compiler can schedule it wherever `std_mult_pipe` is used. It is the area-cheap option: one adder, with a latency that depends on the data. The result is the low `width` bits of `left * right`.

## Interface
- `width`, default 32: operand and result width in bits.

- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high reset.
- `go`  in  1: request. Held high by the controller until `done` is seen.
- `left`  in  `width`: multiplicand. Sampled only at the start edge.
- `right`  in  `width`: multiplier. Sampled only at the start edge.
- `out`  out  `width`: product, low `width` bits.
- `done`  out  1: one-cycle completion pulse.

## Operation
- Internal registers:
  - `state`, one of IDLE, RUN or DONE.
  - `mcand` (`width` bits).
  - `mplier` (`width` bits).
  - `acc` (`width` bits).
- Reset, asynchronous:
  - `state` = IDLE.
  - `out` = 0, `done` = 0.
  - `mcand`, `mplier` and `acc` = 0.
  - Reset wins over every other event, including `go` in the same cycle.
- IDLE:
  - If `go` = 1: load `mcand <= left`, `mplier <= right`, `acc <= 0`, then go to RUN. This is the start edge.
  - If `go` = 0: stay in IDLE. `out` holds its last value.
- RUN, evaluated in priority order:
  1. If `go` = 0: abort. Go to IDLE, `out <= 0`, `done` stays 0.
  2. Else if `mplier` == 0 or `mcand` == 0: `out <= acc`, `done <= 1`, go to DONE.
  3. Else step:
     - if `mplier[0]`, then `acc <= acc + mcand` (mod 2^width);
     - `mcand <= mcand << 1` (bits shifted out are dropped);
     - `mplier <= mplier >> 1`.
- DONE:
  - `done <= 0` and go to IDLE, regardless of `go`.
  - `done` is therefore high for exactly one cycle.
  - `out` holds the product until the next start or abort, or until reset.
- If `go` is still high in IDLE after DONE, a new operation starts using the current `left`/`right`. This matches the other `_pipe` primitives.
- Arithmetic:
  - All operations are unsigned and truncated to `width` bits.
  - Overflow is silent wrap, identical to `std_mult`.
- Changes to `left`/`right` after the start edge have no effect on the running operation.

## Timing
- Define R = bit length of `right` (0 if `right` = 0).
- Define L = `width` − (trailing zeros of `left`), with L = 0 if `left` = 0.
- Latency from the start edge (edge 0) to the edge that raises `done`: 1 + min(L, R) edges.
- `done` is visible for the cycle after that edge.
- Minimum case: `left` = 0 or `right` = 0. `done` rises on edge 1.
- Maximum case: `width` + 1 edges, e.g. `right` = all-ones and `left` odd.
- `out` changes only on:
  - the edge that raises `done` (new product);
  - an abort edge (cleared to 0);
  - reset (cleared to 0).
- There is no combinational path from any input to `out` or `done`.

## Configuration
- `STD_MULT_SEQ_CHECK_EN` defined:
  - Adds a shadow register that captures `left * right` (truncated) at the start edge.
  - On every cycle where `done` = 1, compares `out` against the shadow and issues `$error` with operands, expected and computed values on mismatch.
  - Simulation only. It must not change `out`, `done` or latency.
- Not defined: no shadow register and no checker logic. The RTL is fully synthesizable.

## Test plan
- Zero operand (width = 32): `left` = 0, `right` = 12345, `go` held high.
  - `done` rises on edge 1 with `out` = 0.
  - Repeat with `left` = 7, `right` = 0: same response.
- Basic product: `left` = 6, `right` = 7, `go` held high.
  - `done` high for exactly one cycle, after edge 4 (R = 3).
  - `out` = 42.
  - `out` is still 42 one cycle after `go` drops.
- Wrap and worst case: `left` = 32'hFFFF_FFFF, `right` = 32'hFFFF_FFFF.
  - `out` = 32'h0000_0001.
  - `done` rises on edge 33.
- Operand change mid-run: start with `left` = 100, `right` = 3, then change both to 0 on the next cycle.
  - `out` = 300.
- Abort: start with `left` = 5, `right` = 255, then drop `go` after 3 cycles.
  - No `done` pulse; `out` = 0; state returns to IDLE.
  - Reasserting `go` with 2 × 3 gives `out` = 6.
- Reset mid-operation: assert `reset` asynchronously during RUN (between edges).
  - `out` = 0, `done` = 0 and IDLE immediately.
  - The next operation, 9 × 9, gives 81.
  - Back-to-back starts with `go` held high produce a `done` pulse per operation, each with the correct product.
